// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// keypad_pkg : key codes and entry FSM states for the keypad path
// Rev 1.0
// ---------------------------------------------------------------
package keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BSPC  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// key_debounce : stability filter on the scanner output, one press_evt per press
// Rev 1.0
// ---------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [3:0] key_value,
  output logic       press_evt,
  output logic [3:0] press_val
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [4:0]         w_sample;
  logic               w_stable;
  logic [4:0]         r_cand;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_stable_pressed;
  logic               r_armed;
  logic               r_init;

  assign w_sample = {key_pressed, key_value};
  assign w_stable = (r_cnt == c_cnt_max);

  // r_armed stays low until a stable release is seen, so a key held through
  // reset release cannot fire until it has been let go.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cand           <= '0;
      r_cnt            <= c_cnt_max;
      r_stable_pressed <= 1'b0;
      r_armed          <= 1'b0;
      r_init           <= 1'b1;
    end else begin
      r_init <= 1'b0;
      if (w_sample != r_cand) begin
        r_cand <= w_sample;
        r_cnt  <= '0;
      end else if (!w_stable) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      if (w_stable) begin
        r_stable_pressed <= r_cand[4];
        if (!r_cand[4] && (!r_init || !key_pressed)) begin
          r_armed <= 1'b1;
        end
      end
    end
  end

  assign press_evt = w_stable && r_cand[4] && !r_stable_pressed && r_armed;
  assign press_val = r_cand[3:0];

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// keypad_entry : debounced key events -> BCD product code with valid/ready output
// Rev 1.0
// ---------------------------------------------------------------
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int DIGITS          = 2,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_pressed,
  input  logic [3:0]                   key_value,
  output logic [4*DIGITS-1:0]          code_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         code_valid,
  input  logic                         code_ready,
  output logic                         entry_active,
  output logic                         err_pulse,
  output logic                         timeout_pulse
);

  localparam int c_buf_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(DIGITS + 1);
  localparam int c_tmr_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DIGITS);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic               c_tmr_en   = (TIMEOUT_CYCLES > 0);

  localparam logic [1:0] c_st_idle  = IDLE;
  localparam logic [1:0] c_st_entry = ENTRY;
  localparam logic [1:0] c_st_hold  = HOLD;

  logic               w_evt;
  logic [3:0]         w_key;
  logic [1:0]         r_state, w_state_nx;
  logic [c_buf_w-1:0] r_buf, w_buf_nx;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nx;
  logic               r_err, w_err_nx;
  logic               r_to, w_to_nx;
  logic [c_tmr_w-1:0] r_tmr;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .key_pressed (key_pressed),
    .key_value   (key_value),
    .press_evt   (w_evt),
    .press_val   (w_key)
  );

  always_comb begin
    w_state_nx = r_state;
    w_buf_nx   = r_buf;
    w_cnt_nx   = r_cnt;
    w_err_nx   = 1'b0;
    w_to_nx    = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_evt && is_digit(w_key)) begin
          w_buf_nx   = c_buf_w'(w_key);
          w_cnt_nx   = c_cnt_w'(1);
          w_state_nx = c_st_entry;
        end
      end
      c_st_entry: begin
        // A key event outranks an expiring timeout in the same cycle.
        if (w_evt) begin
          if (is_digit(w_key)) begin
            if (r_cnt < c_full) begin
              w_buf_nx = (r_buf << 4) | c_buf_w'(w_key);
              w_cnt_nx = r_cnt + c_cnt_w'(1);
            end else begin
              w_err_nx = 1'b1;
            end
          end else if (w_key == KEY_BSPC) begin
            w_buf_nx = r_buf >> 4;
            w_cnt_nx = r_cnt - c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(1)) begin
              w_state_nx = c_st_idle;
            end
          end else if (w_key == KEY_CLR) begin
            w_buf_nx   = '0;
            w_cnt_nx   = '0;
            w_state_nx = c_st_idle;
          end else if (w_key == KEY_ENTER) begin
            w_state_nx = c_st_hold;
          end
        end else if (c_tmr_en && (r_tmr == c_tmr_last)) begin
          w_buf_nx   = '0;
          w_cnt_nx   = '0;
          w_to_nx    = 1'b1;
          w_state_nx = c_st_idle;
        end
      end
      c_st_hold: begin
        if (code_ready) begin
          w_buf_nx   = '0;
          w_cnt_nx   = '0;
          w_state_nx = c_st_idle;
        end
      end
      default: begin
        w_buf_nx   = '0;
        w_cnt_nx   = '0;
        w_state_nx = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_to    <= 1'b0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_buf   <= w_buf_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_err_nx;
      r_to    <= w_to_nx;
      if (w_evt || (w_state_nx != r_state)) begin
        r_tmr <= '0;
      end else if (c_tmr_en && (r_state == c_st_entry)) begin
        r_tmr <= r_tmr + c_tmr_w'(1);
      end
    end
  end

  assign code_bcd      = r_buf;
  assign digit_count   = r_cnt;
  assign code_valid    = (r_state == c_st_hold);
  assign entry_active  = (r_state != c_st_idle);
  assign err_pulse     = r_err;
  assign timeout_pulse = r_to;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------
// tb_keypad_entry : directed key sequences, scoreboard on handshake and pulses
// Rev 1.0
// ---------------------------------------------------------------
module tb_keypad_entry;
  import keypad_pkg::*;

  localparam int K_CODE = 0;
  localparam int K_ERR  = 1;
  localparam int K_TO   = 2;

  typedef struct {
    int         kind;
    logic [7:0] bcd;
    logic [1:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_pressed;
  logic [3:0] key_value;
  logic [7:0] code_bcd;
  logic [1:0] digit_count;
  logic       code_valid;
  logic       code_ready;
  logic       entry_active;
  logic       err_pulse;
  logic       timeout_pulse;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  keypad_entry #(
    .DEBOUNCE_CYCLES (4),
    .DIGITS          (2),
    .TIMEOUT_CYCLES  (50)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_pressed   (key_pressed),
    .key_value     (key_value),
    .code_bcd      (code_bcd),
    .digit_count   (digit_count),
    .code_valid    (code_valid),
    .code_ready    (code_ready),
    .entry_active  (entry_active),
    .err_pulse     (err_pulse),
    .timeout_pulse (timeout_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] bcd, input logic [1:0] cnt);
    exp_t e;
    e.kind = kind;
    e.bcd  = bcd;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got unexpected output, want none", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, " kind"}, 32'(kind), 32'(e.kind));
      if (kind == K_CODE) begin
        chk({name, " bcd"}, 32'(code_bcd), 32'(e.bcd));
        chk({name, " count"}, 32'(digit_count), 32'(e.cnt));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (code_valid && code_ready) observe(K_CODE, "handshake");
      if (err_pulse) observe(K_ERR, "err_pulse");
      if (timeout_pulse) observe(K_TO, "timeout_pulse");
    end
  end

  task automatic drive(input logic p, input logic [3:0] v, input int n);
    key_pressed = p;
    key_value   = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] v);
    drive(1'b1, v, 6);
    drive(1'b0, 4'h0, 6);
  endtask

  task automatic outs(input string name, input logic [7:0] bcd, input logic [1:0] cnt,
                      input logic valid, input logic active);
    @(negedge clk);
    chk({name, " code_bcd"}, 32'(code_bcd), 32'(bcd));
    chk({name, " digit_count"}, 32'(digit_count), 32'(cnt));
    chk({name, " code_valid"}, 32'(code_valid), 32'(valid));
    chk({name, " entry_active"}, 32'(entry_active), 32'(active));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!code_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(code_valid), 32'd1);
  endtask

  task automatic wait_entry(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!entry_active && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(entry_active), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, want end of test");
    $fatal(1);
  end

  initial begin
    int valid_hi;
    int cyc;
    reset       = 1'b0;
    key_pressed = 1'b0;
    key_value   = 4'h0;
    code_ready  = 1'b0;
    @(negedge clk);
    chk("reset err_pulse", 32'(err_pulse), 32'd0);
    chk("reset timeout_pulse", 32'(timeout_pulse), 32'd0);
    outs("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b0, 4'h0, 4);

    // 1: glitches filtered, one event per press; value change while held is no event
    drive(1'b1, 4'h3, 2);
    drive(1'b0, 4'h0, 2);
    drive(1'b1, 4'h3, 2);
    drive(1'b0, 4'h0, 2);
    drive(1'b1, 4'h3, 10);
    drive(1'b0, 4'h0, 6);
    outs("s1 glitch", 8'h03, 2'd1, 1'b0, 1'b1);
    press(KEY_CLR);
    outs("s1 clear", 8'h00, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 4'h1, 8);
    drive(1'b1, 4'h2, 8);
    drive(1'b0, 4'h0, 6);
    outs("s1 held change", 8'h01, 2'd1, 1'b0, 1'b1);
    press(KEY_CLR);

    // 2: held code with code_ready low for 5 cycles
    press(4'h1);
    press(4'h2);
    drive(1'b1, KEY_ENTER, 0);
    wait_valid("s2 valid rise");
    valid_hi = 1;
    chk("s2 code_bcd", 32'(code_bcd), 32'h12);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      if (code_valid) valid_hi++;
    end
    push(K_CODE, 8'h12, 2'd2);
    @(posedge clk);
    #1;
    code_ready = 1'b1;
    @(negedge clk);
    if (code_valid) valid_hi++;
    @(posedge clk);
    #1;
    code_ready  = 1'b0;
    key_pressed = 1'b0;
    key_value   = 4'h0;
    chk("s2 valid cycles", 32'(valid_hi), 32'd6);
    outs("s2 after", 8'h00, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 6);

    // 3: overflow error, ignored key, backspace back to IDLE
    press(KEY_ENTER);
    outs("s3 idle enter", 8'h00, 2'd0, 1'b0, 1'b0);
    press(4'h4);
    press(4'h5);
    push(K_ERR, 8'h00, 2'd0);
    press(4'h6);
    outs("s3 full", 8'h45, 2'd2, 1'b0, 1'b1);
    press(4'hE);
    outs("s3 ignored", 8'h45, 2'd2, 1'b0, 1'b1);
    press(KEY_BSPC);
    outs("s3 bspc1", 8'h04, 2'd1, 1'b0, 1'b1);
    press(KEY_BSPC);
    outs("s3 bspc2", 8'h00, 2'd0, 1'b0, 1'b0);

    // 4a: timeout after exactly 50 idle cycles in ENTRY
    push(K_TO, 8'h00, 2'd0);
    key_pressed = 1'b1;
    key_value   = 4'h7;
    wait_entry("s4a entry");
    cyc = 1;
    while (cyc < 200) begin
      @(negedge clk);
      if (timeout_pulse) break;
      cyc++;
      if (cyc == 3) begin
        key_pressed = 1'b0;
        key_value   = 4'h0;
      end
    end
    chk("s4a entry cycles", 32'(cyc), 32'd50);
    chk("s4a code_bcd", 32'(code_bcd), 32'h00);
    chk("s4a entry_active", 32'(entry_active), 32'd0);
    @(posedge clk);
    #1;

    // 4b: key event in cycle 49 restarts the timeout
    push(K_TO, 8'h00, 2'd0);
    key_pressed = 1'b1;
    key_value   = 4'h8;
    wait_entry("s4b entry");
    cyc = 1;
    while (cyc < 200) begin
      @(negedge clk);
      if (timeout_pulse) break;
      cyc++;
      if (cyc == 3 || cyc == 51) begin
        key_pressed = 1'b0;
        key_value   = 4'h0;
      end
      if (cyc == 45) begin
        key_pressed = 1'b1;
        key_value   = 4'h9;
      end
      if (cyc == 50) chk("s4b code_bcd c50", 32'(code_bcd), 32'h89);
    end
    chk("s4b entry cycles", 32'(cyc), 32'd99);
    chk("s4b code_bcd", 32'(code_bcd), 32'h00);
    @(posedge clk);
    #1;

    // 5: keys in HOLD ignored; then zero-wait acceptance
    press(4'h1);
    press(4'h2);
    press(KEY_ENTER);
    outs("s5 hold", 8'h12, 2'd2, 1'b1, 1'b1);
    press(4'h9);
    press(KEY_CLR);
    outs("s5 hold keys", 8'h12, 2'd2, 1'b1, 1'b1);
    push(K_CODE, 8'h12, 2'd2);
    code_ready = 1'b1;
    @(posedge clk);
    #1;
    code_ready = 1'b0;
    outs("s5 accepted", 8'h00, 2'd0, 1'b0, 1'b0);
    code_ready = 1'b1;
    press(4'h5);
    push(K_CODE, 8'h05, 2'd1);
    press(KEY_ENTER);
    code_ready = 1'b0;
    outs("s5 zero wait", 8'h00, 2'd0, 1'b0, 1'b0);

    // 6: reset in HOLD with a key held through reset release
    press(4'h1);
    press(KEY_ENTER);
    outs("s6 hold", 8'h01, 2'd1, 1'b1, 1'b1);
    drive(1'b1, 4'h7, 6);
    reset = 1'b0;
    @(negedge clk);
    chk("s6 reset err_pulse", 32'(err_pulse), 32'd0);
    chk("s6 reset timeout_pulse", 32'(timeout_pulse), 32'd0);
    outs("s6 in reset", 8'h00, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 4'h7, 20);
    outs("s6 held after reset", 8'h00, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 6);
    press(4'h7);
    outs("s6 repress", 8'h07, 2'd1, 1'b0, 1'b1);
    press(KEY_CLR);
    outs("s6 clear", 8'h00, 2'd0, 1'b0, 1'b0);

    drive(1'b0, 4'h0, 10);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
